tage_update_sched: RTL and testbench
====================================

# tage_update_sched

Scheduler that buffers resolved-branch updates and time-shares the single table port of the TAGE predictor between front-end lookups and training updates. Resolved branches from the back end enqueue into an internal FIFO. The block drains one entry per cycle onto the predictor's update port whenever the front end is not looking up. A starvation counter forces an update through after a bounded number of blocked cycles.

## Interface
Parameters:
- DEPTH, 8, update FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive blocked cycles before an update is forced (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  resolved-branch update offered
- in_ready  out  1  FIFO can accept; high iff count < DEPTH
- in_pc  in  32  branch PC
- in_taken  in  1  resolved direction
- in_pred  in  2  counter value used at prediction time
- lookup_req  in  1  front end requests table port this cycle
- lookup_grant  out  1  front end owns table port this cycle
- flush  in  1  discard all queued updates
- upd_valid  out  1  update issued to predictor this cycle
- upd_pc  out  32  head entry PC
- upd_taken  out  1  head entry direction
- upd_pred  out  2  head entry prediction
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter.
- Push when in_valid && in_ready && !flush.
- Pop when upd_valid.
- Simultaneous push and pop leaves count unchanged.
- upd_pc/upd_taken/upd_pred always reflect the head entry. They are don't-care when empty.
- Arbiter FSM, state registered:
  - IDLE: count==0. upd_valid=0, lookup_grant=lookup_req.
  - PEND: count>0, starve_cnt<STARVE_MAX. upd_valid=!lookup_req, lookup_grant=lookup_req.
  - FORCE: count>0, starve_cnt==STARVE_MAX. upd_valid=1, lookup_grant=0.
- Transitions are evaluated on post-update count and starve_cnt.
- starve_cnt behaviour:
  - Increments each cycle in PEND with lookup_req=1. It saturates at STARVE_MAX.
  - Clears on any pop, on empty, and on flush.
- flush:
  - upd_valid=0 that cycle.
  - Pointers, count and starve_cnt clear next cycle, and the state goes to IDLE.
  - A push in the same cycle is dropped.
  - lookup_grant=lookup_req.
- in_ready does not depend on a same-cycle pop. When full, input stalls one cycle even if a pop occurs. There is no combinational path from lookup_req to in_ready.

## Timing
- Reset values:
  - in_ready=1, lookup_grant=lookup_req (combinational).
  - upd_valid=0, count=0, starve_cnt=0, state IDLE.
  - Stats counters are 0.
- Enqueue-to-issue latency is 1 cycle minimum: an entry pushed in cycle N can appear with upd_valid in cycle N+1.
- Throughput is 1 push and 1 pop per cycle.
- Worst-case wait for the head entry under continuous lookup_req is STARVE_MAX blocked cycles, then forced issue on the next.
- upd_valid and lookup_grant are never both 1.
- rst is checked before flush.
- Reset mid-operation discards the queue with no upd_valid pulse.

## Configuration
- TAGE_UPD_STATS_EN defined: adds output ports stat_issued[31:0], stat_forced[31:0] and stat_flushed[31:0].
  - stat_issued counts pops.
  - stat_forced counts pops in FORCE.
  - stat_flushed adds count on each flush.
  - All three wrap at 2^32 and clear on rst.
- TAGE_UPD_STATS_EN undefined: these ports and registers do not exist. Behaviour is otherwise identical.

## Test plan
- Reset, then push 3 entries (PC 0x100/0x104/0x108) with lookup_req=0 → upd_valid in the three cycles following each push, in order, with matching pc/taken/pred; count returns to 0.
- Fill with 8 pushes while lookup_req=1 and STARVE_MAX=4 → in_ready=0 at count=8; first forced upd_valid after 4 blocked cycles with lookup_grant=0; stat_forced=1.
- Full FIFO plus in_valid and pop in the same cycle → push refused (in_ready=0), count drops to 7, and the next cycle accepts.
- Count=5 plus flush with simultaneous in_valid → upd_valid=0, next cycle count=0 and state IDLE; stat_flushed=5.
- Pointer wrap: 20 push/pop pairs through DEPTH=8 → data order preserved and count never exceeds 1.
- Assert rst with count=6 and starve_cnt=3 → next cycle count=0, in_ready=1 and no upd_valid.

Source files
------------

// File: rtl/tage_update_sched.sv
// Update scheduler for the TAGE table port: buffers resolved branches and issues them when the front end is idle.
// Optional stat_issued/stat_forced/stat_flushed counters are built when TAGE_UPD_STATS_EN is defined.
module tage_update_sched #(
  parameter int DEPTH      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_pc,
  input  logic                         in_taken,
  input  logic [1:0]                   in_pred,
  input  logic                         lookup_req,
  output logic                         lookup_grant,
  input  logic                         flush,
  output logic                         upd_valid,
  output logic [31:0]                  upd_pc,
  output logic                         upd_taken,
  output logic [1:0]                   upd_pred,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef TAGE_UPD_STATS_EN
  ,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_forced,
  output logic [31:0]                  stat_flushed
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  pred;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [1:0]      state_q, state_d;
  logic            push, pop;

  // Outputs come from the registered state so lookup_req never reaches in_ready.
  assign in_ready     = (count_q < CW'(DEPTH));
  assign upd_valid    = !rst && !flush &&
                        ((state_q == S_FORCE) || ((state_q == S_PEND) && !lookup_req));
  assign lookup_grant = lookup_req && (rst || flush || (state_q != S_FORCE));
  assign push         = in_valid && in_ready && !flush;
  assign pop          = upd_valid;
  assign count        = count_q;
  assign {upd_pc, upd_taken, upd_pred} = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      starve_d = '0;
      state_d  = S_IDLE;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (pop || (count_d == '0))
        starve_d = '0;
      else if ((state_q == S_PEND) && lookup_req && (starve_q != SW'(STARVE_MAX)))
        starve_d = starve_q + SW'(1);
      if (count_d == '0)
        state_d = S_IDLE;
      else if (starve_d == SW'(STARVE_MAX))
        state_d = S_FORCE;
      else
        state_d = S_PEND;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      state_q  <= state_d;
    end
  end

  // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= '{pc: in_pc, taken: in_taken, pred: in_pred};
  end

`ifdef TAGE_UPD_STATS_EN
  logic [31:0] stat_issued_q, stat_forced_q, stat_flushed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q  <= '0;
      stat_forced_q  <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (pop)
        stat_issued_q <= stat_issued_q + 32'd1;
      if (pop && (state_q == S_FORCE))
        stat_forced_q <= stat_forced_q + 32'd1;
      if (flush)
        stat_flushed_q <= stat_flushed_q + 32'(count_q);
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_forced  = stat_forced_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_tage_update_sched.sv
// Scoreboard bench for tage_update_sched: a cycle model predicts handshake outputs, a queue holds expected updates.
// Stats checks are compiled in when TAGE_UPD_STATS_EN is defined.
module tb_tage_update_sched;

  localparam int DEPTH      = 8;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_taken, lookup_req, flush;
  logic [31:0] in_pc;
  logic [1:0]  in_pred;
  logic        in_ready, lookup_grant, upd_valid, upd_taken;
  logic [31:0] upd_pc;
  logic [1:0]  upd_pred;
  logic [3:0]  count;
`ifdef TAGE_UPD_STATS_EN
  logic [31:0] stat_issued, stat_forced, stat_flushed;
`endif

  tage_update_sched #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_taken(in_taken), .in_pred(in_pred),
    .lookup_req(lookup_req), .lookup_grant(lookup_grant), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .count(count)
`ifdef TAGE_UPD_STATS_EN
    , .stat_issued(stat_issued), .stat_forced(stat_forced), .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state, kept in the spec's own terms.
  int          m_cnt    = 0;
  int          m_starve = 0;
  logic [34:0] sb_q[$];
  logic [31:0] m_issued = 0, m_forced = 0, m_flushed = 0;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic step(input logic r, input logic f, input logic v, input logic lk);
    logic        idle, force_st, pend, e_valid, e_grant, e_ready, do_push;
    logic [34:0] head;
    logic [31:0] pc;
    pc = pc_ctr;
    rst = r; flush = f; in_valid = v; lookup_req = lk;
    in_pc = pc; in_taken = pc[2]; in_pred = pc[4:3];
    @(negedge clk);
    idle     = (m_cnt == 0);
    force_st = !idle && (m_starve == STARVE_MAX);
    pend     = !idle && !force_st;
    e_valid  = !r && !f && (force_st || (pend && !lk));
    e_grant  = lk && !(force_st && !r && !f);
    e_ready  = (m_cnt < DEPTH);
    check("upd_valid", {31'b0, upd_valid}, {31'b0, e_valid});
    check("lookup_grant", {31'b0, lookup_grant}, {31'b0, e_grant});
    check("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
    check("count", {28'b0, count}, m_cnt);
    check("exclusive", {31'b0, upd_valid && lookup_grant}, 32'd0);
`ifdef TAGE_UPD_STATS_EN
    check("stat_issued", stat_issued, m_issued);
    check("stat_forced", stat_forced, m_forced);
    check("stat_flushed", stat_flushed, m_flushed);
`endif
    if (e_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        head = sb_q.pop_front();
        check("upd_pc", upd_pc, head[34:3]);
        check("upd_taken", {31'b0, upd_taken}, {31'b0, head[2]});
        check("upd_pred", {30'b0, upd_pred}, {30'b0, head[1:0]});
      end
    end
    do_push = v && e_ready && !f && !r;
    if (r) begin
      m_cnt = 0; m_starve = 0; sb_q.delete();
      m_issued = 0; m_forced = 0; m_flushed = 0;
    end else if (f) begin
      m_flushed += m_cnt;
      m_cnt = 0; m_starve = 0; sb_q.delete();
    end else begin
      if (do_push) sb_q.push_back({pc, pc[2], pc[4:3]});
      if (e_valid) begin
        m_issued++;
        if (force_st) m_forced++;
      end
      m_cnt = m_cnt + int'(do_push) - int'(e_valid);
      if (e_valid || m_cnt == 0) m_starve = 0;
      else if (pend && lk && m_starve < STARVE_MAX) m_starve++;
    end
    if (do_push) pc_ctr += 32'h4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; lookup_req = 1'b0;
    in_pc = '0; in_taken = 1'b0; in_pred = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);

    // Three pushes with an idle front end issue back to back.
    pc_ctr = 32'h100;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("drained", {28'b0, count}, 32'd0);

    // Continuous lookups: fill to full, starvation forces issues.
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
    if (m_cnt == DEPTH) begin
      step(0, 0, 1, 0);
      check("full_pop_cnt", {28'b0, count}, DEPTH - 1);
      step(0, 0, 1, 0);
    end else begin
      check("reached_full", m_cnt, DEPTH);
    end

    // Drain to five and flush with a simultaneous offer.
    for (int i = 0; i < 10 && m_cnt > 5; i++) step(0, 0, 0, 0);
    check("pre_flush_cnt", {28'b0, count}, 32'd5);
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);

    // Pointer wrap with steady push/pop pairs.
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 0);
      check("wrap_le1", {31'b0, count <= 4'd1}, 32'd1);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Build count=6 with starve=3, then reset.
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_cnt == 6 && m_starve == 3) begin
        reached = 1'b1;
        break;
      end
      step(0, 0, m_cnt < 6, 1);
    end
    check("starve_setup", {31'b0, reached}, 32'd1);
    step(1, 0, 1, 1);
    step(0, 0, 0, 1);
    check("post_rst_cnt", {28'b0, count}, 32'd0);
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
